// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle write-back bypass and load-use bubble insertion.
// The counter tracks how many bubbles the load-use interlock has inserted, saturating at all-ones.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_id_valid,
    input  logic [XLEN-1:0]   i_id_pc,
    input  logic [4:0]        i_id_rs1,
    input  logic [4:0]        i_id_rs2,
    input  logic [4:0]        i_id_rd,
    input  logic [XLEN-1:0]   i_id_rdata1,
    input  logic [XLEN-1:0]   i_id_rdata2,
    input  logic [XLEN-1:0]   i_id_imm,
    input  logic [CTRL_W-1:0] i_id_ctrl,
    input  logic              i_id_regwrite,
    input  logic              i_id_memread,
    input  logic              i_wb_regwrite,
    input  logic [4:0]        i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic              o_ex_valid,
    output logic [XLEN-1:0]   o_ex_pc,
    output logic [XLEN-1:0]   o_ex_imm,
    output logic [4:0]        o_ex_rs1,
    output logic [4:0]        o_ex_rs2,
    output logic [4:0]        o_ex_rd,
    output logic [XLEN-1:0]   o_ex_op1,
    output logic [XLEN-1:0]   o_ex_op2,
    output logic [CTRL_W-1:0] o_ex_ctrl,
    output logic              o_ex_regwrite,
    output logic              o_ex_memread,
    output logic              o_load_use_stall,
    output logic [CNT_W-1:0]  o_bubble_cnt
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_regwrite;
    logic              r_memread;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;
    logic              w_load_use;
    logic              w_clear;
    logic              w_load;
    logic              w_bubble;

    // x0 reads as zero; a write-back to x0 can never match a non-zero source index.
    always_comb begin
        w_op1 = i_id_rdata1;
        if (i_id_rs1 == 5'd0)
            w_op1 = '0;
        else if (i_wb_regwrite && (i_wb_rd == i_id_rs1))
            w_op1 = i_wb_data;
    end

    always_comb begin
        w_op2 = i_id_rdata2;
        if (i_id_rs2 == 5'd0)
            w_op2 = '0;
        else if (i_wb_regwrite && (i_wb_rd == i_id_rs2))
            w_op2 = i_wb_data;
    end

    assign w_load_use = i_id_valid & r_valid & r_memread & (r_rd != 5'd0) &
                        ((r_rd == i_id_rs1) | (r_rd == i_id_rs2));

    // Flush beats stall beats load-use; a stalled EX keeps the hazard visible upstream.
    assign w_bubble = ~i_flush & ~i_stall & w_load_use;
    assign w_clear  = i_flush | w_bubble;
    assign w_load   = ~i_flush & ~i_stall & ~w_load_use;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_ctrl     <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
        end else if (w_clear) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_ctrl     <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
        end else if (w_load) begin
            r_valid    <= i_id_valid;
            r_pc       <= i_id_pc;
            r_imm      <= i_id_imm;
            r_rs1      <= i_id_rs1;
            r_rs2      <= i_id_rs2;
            r_rd       <= i_id_rd;
            r_op1      <= w_op1;
            r_op2      <= w_op2;
            // An invalid slot carries its data but can never cause a side effect.
            r_ctrl     <= i_id_valid ? i_id_ctrl : '0;
            r_regwrite <= i_id_valid & i_id_regwrite;
            r_memread  <= i_id_valid & i_id_memread;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_bubble_cnt <= '0;
        else if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}}))
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end

    assign o_ex_valid       = r_valid;
    assign o_ex_pc          = r_pc;
    assign o_ex_imm         = r_imm;
    assign o_ex_rs1         = r_rs1;
    assign o_ex_rs2         = r_rs2;
    assign o_ex_rd          = r_rd;
    assign o_ex_op1         = r_op1;
    assign o_ex_op2         = r_op2;
    assign o_ex_ctrl        = r_ctrl;
    assign o_ex_regwrite    = r_regwrite;
    assign o_ex_memread     = r_memread;
    assign o_load_use_stall = w_load_use;
    assign o_bubble_cnt     = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, bypass, load-use, priority, saturation.
// The counter is built 4 bits wide so saturation is reachable in a short run.
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 12;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic [XLEN-1:0]   id_rdata1;
    logic [XLEN-1:0]   id_rdata2;
    logic [XLEN-1:0]   id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_regwrite;
    logic              id_memread;
    logic              wb_regwrite;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [XLEN-1:0]   ex_op1;
    logic [XLEN-1:0]   ex_op2;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              load_use_stall;
    logic [CNT_W-1:0]  bubble_cnt;

    int n_tests;
    int n_fail;
    int exp_bub;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
        .i_id_valid(id_valid), .i_id_pc(id_pc), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_rd(id_rd), .i_id_rdata1(id_rdata1), .i_id_rdata2(id_rdata2),
        .i_id_imm(id_imm), .i_id_ctrl(id_ctrl), .i_id_regwrite(id_regwrite),
        .i_id_memread(id_memread), .i_wb_regwrite(wb_regwrite), .i_wb_rd(wb_rd),
        .i_wb_data(wb_data), .o_ex_valid(ex_valid), .o_ex_pc(ex_pc), .o_ex_imm(ex_imm),
        .o_ex_rs1(ex_rs1), .o_ex_rs2(ex_rs2), .o_ex_rd(ex_rd), .o_ex_op1(ex_op1),
        .o_ex_op2(ex_op2), .o_ex_ctrl(ex_ctrl), .o_ex_regwrite(ex_regwrite),
        .o_ex_memread(ex_memread), .o_load_use_stall(load_use_stall),
        .o_bubble_cnt(bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] rd1, input logic [31:0] rd2,
                             input logic [31:0] imm, input logic [11:0] ctrl,
                             input logic rw, input logic mr);
        id_valid = v;  id_pc = pc;  id_rs1 = rs1;  id_rs2 = rs2;  id_rd = rd;
        id_rdata1 = rd1;  id_rdata2 = rd2;  id_imm = imm;  id_ctrl = ctrl;
        id_regwrite = rw;  id_memread = mr;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
        wb_regwrite = en;  wb_rd = rd;  wb_data = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;  stall = 1'b0;  flush = 1'b0;
        set_instr(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h7, 12'h123, 1'b1, 1'b1);
        set_wb(1'b0, 5'd0, 32'h0);
        #2;
        n_tests++;
        if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_op1 !== 32'h0 || ex_ctrl !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_regs: valid=%b pc=%h op1=%h ctrl=%h, required all 0",
                     ex_valid, ex_pc, ex_op1, ex_ctrl);
        end
        n_tests++;
        if (bubble_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_bubble: got %0d, required 0", bubble_cnt);
        end
        step();
        rst_n = 1'b1;
        set_instr(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 12'h0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_pass_through();
        set_instr(1'b1, 32'h100, 5'd3, 5'd4, 5'd9, 32'h11, 32'h22, 32'h55, 12'hABC, 1'b1, 1'b0);
        step();
        n_tests++;
        if (ex_op1 !== 32'h11 || ex_op2 !== 32'h22 || ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_ops: op1=%h op2=%h valid=%b, required 11 22 1", ex_op1, ex_op2, ex_valid);
        end
        n_tests++;
        if (ex_pc !== 32'h100 || ex_imm !== 32'h55 || ex_ctrl !== 12'hABC || ex_rd !== 5'd9 ||
            ex_rs1 !== 5'd3 || ex_rs2 !== 5'd4 || ex_regwrite !== 1'b1 || ex_memread !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_fields: pc=%h imm=%h ctrl=%h rd=%0d rs1=%0d rs2=%0d rw=%b mr=%b, required 100 55 abc 9 3 4 1 0",
                     ex_pc, ex_imm, ex_ctrl, ex_rd, ex_rs1, ex_rs2, ex_regwrite, ex_memread);
        end
        // Invalid slot: side-effect fields forced low, ex_valid follows id_valid.
        set_instr(1'b0, 32'h104, 5'd3, 5'd4, 5'd9, 32'h11, 32'h22, 32'h55, 12'hFFF, 1'b1, 1'b1);
        step();
        n_tests++;
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0 || ex_ctrl !== 12'h0) begin
            n_fail++;
            $display("FAIL invalid_slot: valid=%b rw=%b mr=%b ctrl=%h, required 0 0 0 000",
                     ex_valid, ex_regwrite, ex_memread, ex_ctrl);
        end
    endtask

    task automatic test_bypass();
        set_instr(1'b1, 32'h200, 5'd5, 5'd6, 5'd10, 32'hAAAA, 32'h66, 32'h0, 12'h001, 1'b1, 1'b0);
        set_wb(1'b1, 5'd5, 32'h1234);
        step();
        n_tests++;
        if (ex_op1 !== 32'h1234 || ex_op2 !== 32'h66) begin
            n_fail++;
            $display("FAIL bypass_rs1: op1=%h op2=%h, required 1234 66", ex_op1, ex_op2);
        end
        set_instr(1'b1, 32'h204, 5'd5, 5'd8, 5'd10, 32'hAAAA, 32'hBBBB, 32'h0, 12'h001, 1'b1, 1'b0);
        set_wb(1'b1, 5'd8, 32'h5678);
        step();
        n_tests++;
        if (ex_op1 !== 32'hAAAA || ex_op2 !== 32'h5678) begin
            n_fail++;
            $display("FAIL bypass_rs2: op1=%h op2=%h, required aaaa 5678", ex_op1, ex_op2);
        end
        set_instr(1'b1, 32'h208, 5'd0, 5'd0, 5'd10, 32'hAAAA, 32'hCCCC, 32'h0, 12'h001, 1'b1, 1'b0);
        set_wb(1'b1, 5'd0, 32'h1234);
        step();
        n_tests++;
        if (ex_op1 !== 32'h0 || ex_op2 !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_x0: op1=%h op2=%h, required 0 0", ex_op1, ex_op2);
        end
        set_instr(1'b1, 32'h20C, 5'd5, 5'd6, 5'd10, 32'hAAAA, 32'h66, 32'h0, 12'h001, 1'b1, 1'b0);
        set_wb(1'b0, 5'd5, 32'h1234);
        step();
        n_tests++;
        if (ex_op1 !== 32'hAAAA) begin
            n_fail++;
            $display("FAIL bypass_wb_off: op1=%h, required aaaa", ex_op1);
        end
        set_wb(1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_load_use();
        set_instr(1'b1, 32'h300, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h8, 12'h010, 1'b1, 1'b1);
        step();
        set_instr(1'b1, 32'h304, 5'd3, 5'd7, 5'd11, 32'h33, 32'h77, 32'h0, 12'h020, 1'b1, 1'b0);
        #1;
        n_tests++;
        if (load_use_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_detect: load_use_stall=%b, required 1", load_use_stall);
        end
        step();
        exp_bub = exp_bub + 1;
        n_tests++;
        if (ex_valid !== 1'b0 || ex_memread !== 1'b0 || ex_rd !== 5'd0 || bubble_cnt !== 4'(exp_bub)) begin
            n_fail++;
            $display("FAIL lu_bubble: valid=%b mr=%b rd=%0d cnt=%0d, required 0 0 0 %0d",
                     ex_valid, ex_memread, ex_rd, bubble_cnt, exp_bub);
        end
        n_tests++;
        if (load_use_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_clear: load_use_stall=%b, required 0", load_use_stall);
        end
        step();
        n_tests++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h304 || ex_rs2 !== 5'd7 || ex_op2 !== 32'h77) begin
            n_fail++;
            $display("FAIL lu_dependent: valid=%b pc=%h rs2=%0d op2=%h, required 1 304 7 77",
                     ex_valid, ex_pc, ex_rs2, ex_op2);
        end
        // A load targeting x0 never creates a hazard.
        set_instr(1'b1, 32'h308, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 12'h010, 1'b1, 1'b1);
        step();
        set_instr(1'b1, 32'h30C, 5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h0, 12'h020, 1'b1, 1'b0);
        #1;
        n_tests++;
        if (load_use_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_x0: load_use_stall=%b, required 0", load_use_stall);
        end
        step();
    endtask

    task automatic test_priority();
        set_instr(1'b1, 32'h400, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0, 12'h010, 1'b1, 1'b1);
        step();
        set_instr(1'b1, 32'h404, 5'd7, 5'd3, 5'd13, 32'h0, 32'h0, 32'h0, 12'h020, 1'b1, 1'b0);
        stall = 1'b1;
        step();
        n_tests++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h400 || ex_rd !== 5'd7 || ex_memread !== 1'b1 ||
            bubble_cnt !== 4'(exp_bub)) begin
            n_fail++;
            $display("FAIL stall_hazard_hold: valid=%b pc=%h rd=%0d mr=%b cnt=%0d, required 1 400 7 1 %0d",
                     ex_valid, ex_pc, ex_rd, ex_memread, bubble_cnt, exp_bub);
        end
        n_tests++;
        if (load_use_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hazard_flag: load_use_stall=%b, required 1", load_use_stall);
        end
        flush = 1'b1;
        step();
        n_tests++;
        if (ex_valid !== 1'b0 || ex_memread !== 1'b0 || ex_pc !== 32'h0 || bubble_cnt !== 4'(exp_bub)) begin
            n_fail++;
            $display("FAIL flush_over_stall: valid=%b mr=%b pc=%h cnt=%0d, required 0 0 0 %0d",
                     ex_valid, ex_memread, ex_pc, bubble_cnt, exp_bub);
        end
        stall = 1'b0;
        flush = 1'b0;
        set_instr(1'b1, 32'h408, 5'd1, 5'd2, 5'd14, 32'h0, 32'h0, 32'h0, 12'h030, 1'b1, 1'b0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_tests++;
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_ctrl !== 12'h0 || ex_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL flush_alone: valid=%b rw=%b ctrl=%h rd=%0d, required 0 0 000 0",
                     ex_valid, ex_regwrite, ex_ctrl, ex_rd);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            set_instr(1'b1, 32'h500, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0, 12'h010, 1'b1, 1'b1);
            step();
            set_instr(1'b1, 32'h504, 5'd7, 5'd0, 5'd15, 32'h0, 32'h0, 32'h0, 12'h020, 1'b1, 1'b0);
            step();
        end
        exp_bub = (exp_bub + 20 > 15) ? 15 : exp_bub + 20;
        n_tests++;
        if (bubble_cnt !== 4'(exp_bub)) begin
            n_fail++;
            $display("FAIL saturation: cnt=%0d, required %0d", bubble_cnt, exp_bub);
        end
    endtask

    task automatic test_async_reset();
        set_instr(1'b1, 32'h600, 5'd3, 5'd4, 5'd9, 32'h99, 32'h88, 32'h1, 12'h0F0, 1'b1, 1'b1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ex_valid !== 1'b0 || ex_op1 !== 32'h0 || ex_rd !== 5'd0 || ex_memread !== 1'b0 ||
            bubble_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b op1=%h rd=%0d mr=%b cnt=%0d, required all 0",
                     ex_valid, ex_op1, ex_rd, ex_memread, bubble_cnt);
        end
        rst_n = 1'b1;
        exp_bub = 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_bub = 0;
        test_reset();
        test_pass_through();
        test_bypass();
        test_load_use();
        test_priority();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
